bpu_btb_ras: RTL
================

# bpu_btb_ras

Parametrised branch predictor for the fetch stage: a set-associative branch target buffer with per-entry 2-bit saturating counters and branch-type tags, plus a return address stack. A lookup is issued with the pre-IF PC and answered in the following cycle, so the result lines up with the instruction in IF. Training comes from EX through the resolved-branch update port.

## Interface
- `SETS`, 128: number of sets; power of 2. `IDX_W = log2(SETS)`.
- `WAYS`, 2: associativity; must be 1, 2 or 4.
- `TAG_W`, 22: tag bits taken from `pc[IDX_W+TAG_W+1 : IDX_W+2]`; requires `IDX_W+TAG_W+2 <= 32`.
- `RAS_DEPTH`, 8: return stack entries; power of 2.
- `clk` in 1: clock; all state is updated on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `lkp_req` in 1: lookup request for `lkp_pc`.
- `lkp_pc` in 32: pre-IF PC.
- `lkp_stall` in 1: hold; while high, the lookup stage register keeps its value.
- `pred_valid` out 1: the stage register holds a lookup.
- `pred_hit` out 1: tag hit in the BTB.
- `pred_taken` out 1: predicted taken.
- `pred_target` out 32: predicted next-fetch address.
- `pred_cnt` out 2: counter value of the hit entry; 0 on a miss.
- `upd_valid` in 1: EX reports a resolved control-flow instruction.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_taken` in 1: actual branch direction.
- `upd_target` in 32: actual target address.
- `upd_type` in 2: branch type; 00 conditional, 01 unconditional jump, 10 call, 11 return.

## Operation
- **Counter encoding:** 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
  - Prediction for conditional branches is `cnt[1]`.
- **Entry contents:** valid, tag, cnt, type, target.
  - All entries are flop-based and read asynchronously.
- **Lookup:**
  - On a rising edge with `lkp_req && !lkp_stall`, the stage register latches `lkp_pc` and its valid bit is set.
  - With `!lkp_req && !lkp_stall`, the valid bit is cleared.
  - While stalled, both the PC and the valid bit hold.
  - Outputs are combinational from the stage register and the current array/RAS contents.
- **Hit:** `pred_hit = 1` when some way of set `pc[IDX_W+1:2]` is valid with a matching tag. `WAYS` never match simultaneously by construction.
- **Prediction by type:**
  - Conditional: `taken = cnt[1]`.
  - Jump and call: always taken.
  - Return: taken.
- **Target:**
  - Taken return: RAS top if the RAS is non-empty, else the entry target.
  - Other taken types: entry target.
  - Not taken or miss: `pc + 8`, which skips the delay slot.
- **Update, hit way:**
  - Conditional: saturating increment if taken, decrement if not.
  - Other types: cnt is forced to 11.
  - Target and type are rewritten.
- **Update, miss:**
  - Allocate the lowest-index invalid way. If no way is invalid, allocate the way given by the per-set round-robin pointer, then advance the pointer modulo `WAYS`.
  - New cnt: 10 if taken, 01 if not taken; non-conditional types get 11.
  - A not-taken conditional branch that misses is still allocated.
- **RAS:** updated at resolution only; there is no speculative update.
  - Call pushes `upd_pc + 8`. The pointer wraps modulo `RAS_DEPTH`; the count saturates at `RAS_DEPTH`, so overflow overwrites the oldest entry.
  - Return pops: pointer decrements, count decrements.
  - Pop when empty is ignored and the count stays 0.
- **Width rules:** `pc + 8` and `upd_pc + 8` are 32-bit and wrap modulo 2^32.
- **Reset:**
  - Clears all valid bits, cnt, round-robin pointers, the RAS pointer/count and the stage register.
  - All outputs read 0 during and after reset until the first accepted lookup; `pred_target` is 0 while `pred_valid` is 0.
  - A reset asserted mid-operation clears state immediately, with no edge needed.

## Timing
- Lookup latency is 1 cycle: request at edge N, result valid during cycle N+1.
- An update sampled at edge N is visible to lookups from cycle N+1.
- A lookup and an update to the same set in the same cycle: the lookup sees the pre-update contents.
- Update is single-cycle and always accepted; there is no backpressure.
- `upd_valid` with `upd_type` = 10 and 11 simultaneously is impossible.
- No stall interaction: updates proceed while `lkp_stall` is high.

## Test plan
- **Reset:** hold `resetn` low, then release and issue a lookup at 0xBFC00000 -> `pred_valid = 1`, `pred_hit = 0`, `pred_taken = 0`, `pred_target = 0xBFC00008`, `pred_cnt = 0`.
- **Conditional training:**
  - Update cond at 0x80001000, taken, target 0x80002000, then look up 0x80001000 -> hit, cnt 10, taken, target 0x80002000.
  - Three not-taken updates -> cnt 00, `pred_target` 0x80001008.
- **Associativity/replacement** (`WAYS` = 2): allocate 3 PCs mapping to set 5 with distinct tags -> the first two fill ways 0 and 1. The third replaces way 0, so a lookup of the first PC misses and the other two hit.
- **RAS:**
  - Call at 0x80000100, then a return entry at 0x80000400 trained -> return lookup gives target 0x80000108.
  - Nine calls with `RAS_DEPTH` = 8, then eight returns -> targets come back in LIFO order. A ninth pop is ignored and the target falls back to the entry target.
- **Stall and same-cycle update:**
  - Assert `lkp_stall` for 3 cycles -> outputs are unchanged.
  - Update and lookup of the same set in one cycle -> old prediction this cycle, new one next cycle.
- **Async reset mid-stream:** pull `resetn` low between edges after training -> outputs go to 0 at once, and subsequent lookups miss.

Source files
------------

// File: rtl/bpu_btb_ras.sv
// bpu_btb_ras: set-associative BTB with 2-bit counters and branch types, plus a return address stack
//   lookup : lkp_req/lkp_pc sampled into a stage register (held by lkp_stall), answered next cycle
//   predict: pred_valid/hit/taken/target/cnt, combinational from the stage register and live state
//   update : upd_valid/pc/taken/target/type from EX trains the BTB and pushes/pops the RAS
module bpu_btb_ras #(
   parameter int SETS      = 128,
   parameter int WAYS      = 2,
   parameter int TAG_W     = 22,
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        lkp_req,
   input  logic [31:0] lkp_pc,
   input  logic        lkp_stall,
   output logic        pred_valid,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic [1:0]  pred_cnt,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic [1:0]  upd_type
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [1:0] T_COND = 2'b00;
   localparam logic [1:0] T_CALL = 2'b10;
   localparam logic [1:0] T_RET  = 2'b11;
   localparam logic [RAS_W:0] RAS_FULL = (RAS_W + 1)'(RAS_DEPTH);
   localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);

   logic [WAYS-1:0]  vld_q [SETS];
   logic [WAYS-1:0]  vld_d [SETS];
   logic [TAG_W-1:0] tag_q [SETS][WAYS];
   logic [TAG_W-1:0] tag_d [SETS][WAYS];
   logic [1:0]       cnt_q [SETS][WAYS];
   logic [1:0]       cnt_d [SETS][WAYS];
   logic [1:0]       typ_q [SETS][WAYS];
   logic [1:0]       typ_d [SETS][WAYS];
   logic [31:0]      tgt_q [SETS][WAYS];
   logic [31:0]      tgt_d [SETS][WAYS];
   logic [WAY_W-1:0] rr_q  [SETS];
   logic [WAY_W-1:0] rr_d  [SETS];
   logic [31:0]      ras_q [RAS_DEPTH];
   logic [31:0]      ras_d [RAS_DEPTH];
   logic [RAS_W-1:0] ras_ptr_q, ras_ptr_d;
   logic [RAS_W:0]   ras_cnt_q, ras_cnt_d;
   logic             val_q, val_d;
   logic [31:0]      pc_q, pc_d;

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             l_hit, u_hit, u_free, l_taken;
   logic [WAY_W-1:0] l_way, u_way, u_fway, u_sel;
   logic [1:0]       l_cnt, l_typ, u_old, u_cnt;
   logic [31:0]      l_tgt, ras_top;

   assign l_idx = pc_q[IDX_W+1:2];
   assign l_tag = pc_q[IDX_W+TAG_W+1:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   assign val_d = lkp_stall ? val_q : lkp_req;
   assign pc_d  = (!lkp_stall && lkp_req) ? lkp_pc : pc_q;

   // Tag match for the held lookup and for the update; ways never match twice.
   always_comb begin
      l_hit  = 1'b0;
      l_way  = '0;
      u_hit  = 1'b0;
      u_way  = '0;
      u_free = 1'b0;
      u_fway = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (vld_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
            l_hit = 1'b1;
            l_way = WAY_W'(w);
         end
         if (vld_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
            u_hit = 1'b1;
            u_way = WAY_W'(w);
         end
      end
      // Descending scan leaves the lowest-index invalid way selected.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!vld_q[u_idx][w]) begin
            u_free = 1'b1;
            u_fway = WAY_W'(w);
         end
      end
   end

   assign l_cnt   = l_hit ? cnt_q[l_idx][l_way] : 2'b00;
   assign l_typ   = typ_q[l_idx][l_way];
   assign l_tgt   = tgt_q[l_idx][l_way];
   assign ras_top = ras_q[ras_ptr_q - RAS_W'(1)];
   assign l_taken = l_hit && (l_typ == T_COND ? l_cnt[1] : 1'b1);

   assign pred_valid  = val_q;
   assign pred_hit    = val_q && l_hit;
   assign pred_taken  = val_q && l_taken;
   assign pred_cnt    = val_q ? l_cnt : 2'b00;
   assign pred_target = !val_q ? 32'd0 :
                        !l_taken ? pc_q + 32'd8 :
                        (l_typ == T_RET && ras_cnt_q != '0) ? ras_top : l_tgt;

   assign u_sel = u_hit ? u_way : u_free ? u_fway : rr_q[u_idx];
   assign u_old = cnt_q[u_idx][u_way];
   assign u_cnt = upd_type != T_COND ? 2'b11 :
                  !u_hit ? (upd_taken ? 2'b10 : 2'b01) :
                  upd_taken ? (u_old == 2'b11 ? u_old : u_old + 2'd1) :
                  (u_old == 2'b00 ? u_old : u_old - 2'd1);

   always_comb begin
      vld_d     = vld_q;
      tag_d     = tag_q;
      cnt_d     = cnt_q;
      typ_d     = typ_q;
      tgt_d     = tgt_q;
      rr_d      = rr_q;
      ras_d     = ras_q;
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (upd_valid) begin
         vld_d[u_idx][u_sel] = 1'b1;
         tag_d[u_idx][u_sel] = u_tag;
         cnt_d[u_idx][u_sel] = u_cnt;
         typ_d[u_idx][u_sel] = upd_type;
         tgt_d[u_idx][u_sel] = upd_target;
         // Round-robin only advances when it actually chose the victim.
         if (!u_hit && !u_free)
            rr_d[u_idx] = rr_q[u_idx] == WAY_LAST ? '0 : rr_q[u_idx] + WAY_W'(1);
         // Overflow keeps the count full while the pointer wraps over the oldest entry.
         if (upd_type == T_CALL) begin
            ras_d[ras_ptr_q] = upd_pc + 32'd8;
            ras_ptr_d        = ras_ptr_q + RAS_W'(1);
            ras_cnt_d        = ras_cnt_q == RAS_FULL ? ras_cnt_q : ras_cnt_q + (RAS_W + 1)'(1);
         end else if (upd_type == T_RET && ras_cnt_q != '0) begin
            ras_ptr_d = ras_ptr_q - RAS_W'(1);
            ras_cnt_d = ras_cnt_q - (RAS_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q     <= '{default: '0};
         tag_q     <= '{default: '0};
         cnt_q     <= '{default: '0};
         typ_q     <= '{default: '0};
         tgt_q     <= '{default: '0};
         rr_q      <= '{default: '0};
         ras_q     <= '{default: '0};
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
         val_q     <= 1'b0;
         pc_q      <= '0;
      end else begin
         vld_q     <= vld_d;
         tag_q     <= tag_d;
         cnt_q     <= cnt_d;
         typ_q     <= typ_d;
         tgt_q     <= tgt_d;
         rr_q      <= rr_d;
         ras_q     <= ras_d;
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
         val_q     <= val_d;
         pc_q      <= pc_d;
      end
   end
endmodule
